floo_mcast_fork: RTL and testbench
==================================

# floo_mcast_fork

Replicates one flit stream onto up to NumOutputs destinations for multicast flits, including ring-on-mesh flits. It sits between an input port's route-select stage and the per-output wormhole arbiters of the multicast router. The block forks each flit to every output selected in a multi-hot route mask and holds the flit until every selected output has accepted it. The mask is latched per packet so body flits follow the head flit's fan-out.

## Interface
Parameters:
- NumOutputs, 5, number of fork destinations (≥1).
- flit_t, logic, flit type; must contain field `hdr.last` (1 = final flit of packet).
- EnErrCount, 1'b1, instantiate 16-bit drop counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream flit valid.
- ready_o  out  1  upstream flit consumed.
- data_i  in  flit_t  upstream flit.
- sel_i  in  NumOutputs  multi-hot route mask from route select; sampled only on head flits.
- valid_o  out  NumOutputs  per-destination valid.
- ready_i  in  NumOutputs  per-destination ready.
- data_o  out  flit_t  flit broadcast to all destinations; equals data_i.
- drop_o  out  1  one-cycle pulse when a flit with empty effective mask is discarded.
- drop_cnt_o  out  16  saturating count of drops; tied '0 if !EnErrCount.

## Operation
- State registers:
  - sent_q[NumOutputs]: destinations that already took the current flit.
  - in_pkt_q: between head flit and last flit.
  - mask_q[NumOutputs]: latched fan-out.
  - drop_cnt_q.
- Effective mask: sel_eff = in_pkt_q ? mask_q : sel_i.
- valid_o[k] = valid_i & sel_eff[k] & ~sent_q[k]. It never depends on ready_i.
- done = sent_q | (valid_o & ready_i).
- ready_o = valid_i & ((done & sel_eff) == sel_eff). With sel_eff == 0 this gives ready_o = valid_i; the flit is dropped and drop_o = 1.
- Partial acceptance (valid_i & !ready_o): sent_q <= sent_q | (valid_o & ready_i). Destinations already served see no further valid.
- Flit completion (valid_i & ready_o): sent_q <= 0.
  - If !data_i.hdr.last: in_pkt_q <= 1 and mask_q <= sel_eff.
  - If data_i.hdr.last: in_pkt_q <= 0 and mask_q <= 0.
- Single-flit packet (head with last = 1): in_pkt_q stays 0 and mask_q is not updated.
- Packet FSM has two states:
  - IDLE (in_pkt_q = 0): head flit completes with last = 0 → BODY.
  - BODY (in_pkt_q = 1): flit completes with last = 1 → IDLE.
- Drop counter: increments on each drop_o and saturates at 16'hFFFF.
- Upstream must hold data_i and valid_i stable while valid_i & !ready_o. A violation is an assertion failure, not a handled case.

## Timing
- Zero-cycle latency: valid_o and data_o are combinational from valid_i, data_i and state. ready_o is combinational from ready_i.
- A flit completes in the cycle the last outstanding selected destination asserts ready_i. That can be the first cycle, if all are ready.
- Minimum flit cycle: 1. Back-to-back flits at full rate when all selected destinations are ready.
- Reset values: sent_q = 0, in_pkt_q = 0, mask_q = 0, drop_cnt_q = 0. With valid_i = 0, outputs are valid_o = 0, ready_o = 0, drop_o = 0, drop_cnt_o = 0.
- Reset asserted mid-packet or mid-fork: all state clears asynchronously. The next valid flit is treated as a head flit and sel_i is sampled again.
- Same-cycle acceptance and completion: when the final outstanding ready_i arrives together with earlier-accepted destinations already in sent_q, completion takes priority. sent_q goes to 0, not to the OR.
- sel_i changes during BODY are ignored.

## Test plan
- Unicast: sel_i = 5'b00100, all ready, 3-flit packet.
  - Required: valid_o = 5'b00100 and ready_o = 1 each cycle.
  - Required: packet done in 3 cycles; in_pkt_q back to 0.
- Staggered multicast: sel_i = 5'b10011, 1-flit packet. ready_i[0] in cycle 0, ready_i[1] in cycle 2, ready_i[4] in cycle 3.
  - Required valid_o: 10011 → 10010 → 10010 → 10000.
  - Required: ready_o = 1 only in cycle 3; then sent_q = 0.
- Mask latch: head with sel_i = 5'b01001, last = 0; sel_i changed to 5'b00110 before body flits.
  - Required: body flits still fork to 01001.
  - Required: after the last flit, the next head uses the new sel_i.
- Empty mask: sel_i = 0, valid_i = 1 for 4 single-flit packets.
  - Required: ready_o = 1 and drop_o = 1 each cycle; drop_cnt_o = 4.
  - Required: counter saturates at 16'hFFFF when preloaded by 65540 drops.
- Reset mid-fork: sel_i = 5'b11111, 2 destinations accepted, rst_ni pulsed low.
  - Required: sent_q = 0 and in_pkt_q = 0.
  - Required: on re-present, all 5 destinations see valid_o again.
- Back-pressure stability: random ready_i.
  - Required: valid_o[k] never falls before ready_i[k] & valid_o[k].
  - Required: data_o stays stable while any valid_o is high.

Source files
------------

// File: rtl/floo_mcast_fork.sv
// Multicast fork: replicates one flit stream onto a multi-hot set of outputs and
// holds each flit until every selected output has taken it. Fan-out is latched per packet.
package floo_mcast_fork_pkg;

    typedef struct packed {
        logic       last;
        logic [6:0] id;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [23:0] payload;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

endpackage

module floo_mcast_fork #(
    parameter int unsigned NumOutputs = 5,
    parameter type         flit_t     = floo_mcast_fork_pkg::flit_t,
    parameter bit          EnErrCount = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both
    // high. valid_o never depends on ready_i; upstream holds data_i/valid_i while stalled.
    input  logic                            valid_i,
    output logic                            ready_o,
    input  flit_t                           data_i,
    input  logic [NumOutputs-1:0]           sel_i,
    output logic [NumOutputs-1:0]           valid_o,
    input  logic [NumOutputs-1:0]           ready_i,
    output flit_t                           data_o,
    output logic                            drop_o,
    output logic [15:0]                     drop_cnt_o,
    output floo_mcast_fork_pkg::pkt_state_e state_o,
    output logic [NumOutputs-1:0]           sent_o
);

    floo_mcast_fork_pkg::pkt_state_e state_q;
    logic [NumOutputs-1:0] sent_q;
    logic [NumOutputs-1:0] mask_q;
    logic [NumOutputs-1:0] sel_eff;
    logic [NumOutputs-1:0] done;
    logic                  in_pkt;
    logic                  fire;

    // Body flits reuse the head's fan-out; sel_i only matters outside a packet.
    assign in_pkt  = (state_q == floo_mcast_fork_pkg::BODY);
    assign sel_eff = in_pkt ? mask_q : sel_i;
    assign valid_o = {NumOutputs{valid_i}} & sel_eff & ~sent_q;
    assign done    = sent_q | (valid_o & ready_i);
    assign ready_o = valid_i & ((done & sel_eff) == sel_eff);
    assign fire    = ready_o;
    assign drop_o  = fire & (sel_eff == '0);
    assign data_o  = data_i;
    assign state_o = state_q;
    assign sent_o  = sent_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= floo_mcast_fork_pkg::IDLE;
            sent_q  <= '0;
            mask_q  <= '0;
        end else begin
            if (fire) begin
                sent_q <= '0;
            end else if (valid_i) begin
                sent_q <= done;
            end
            case (state_q)
                floo_mcast_fork_pkg::IDLE: begin
                    if (fire && !data_i.hdr.last) begin
                        state_q <= floo_mcast_fork_pkg::BODY;
                        mask_q  <= sel_eff;
                    end
                end
                floo_mcast_fork_pkg::BODY: begin
                    if (fire && data_i.hdr.last) begin
                        state_q <= floo_mcast_fork_pkg::IDLE;
                        mask_q  <= '0;
                    end
                end
                default: begin
                    state_q <= floo_mcast_fork_pkg::IDLE;
                    mask_q  <= '0;
                end
            endcase
        end
    end

    if (EnErrCount) begin : gen_drop_cnt
        logic [15:0] drop_cnt_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                drop_cnt_q <= '0;
            end else if (drop_o && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
        assign drop_cnt_o = drop_cnt_q;
    end else begin : gen_no_drop_cnt
        assign drop_cnt_o = '0;
    end

`ifndef SYNTHESIS
    // A stalled flit must stay presented and unchanged until it completes.
    stable_upstream: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (valid_i && $stable(data_i)));
`endif

endmodule

// File: tb/tb_floo_mcast_fork.sv
// Bench for floo_mcast_fork: directed per-cycle vectors checked by a queue-based monitor,
// then a random back-pressure phase checked for hold and exact-once fan-out.
module tb_floo_mcast_fork;
    import floo_mcast_fork_pkg::*;

    localparam int N  = 5;
    localparam int FW = $bits(flit_t);
    localparam int W  = N + 2 + FW;

    logic             clk;
    logic             rst_n;
    logic             valid_i;
    logic             ready_o;
    flit_t            data_i;
    flit_t            data_o;
    logic [N-1:0]     sel_i;
    logic [N-1:0]     valid_o;
    logic [N-1:0]     ready_i;
    logic             drop_o;
    logic [15:0]      drop_cnt_o;
    pkt_state_e       state_o;
    logic [N-1:0]     sent_o;

    int               errors = 0;
    int               checks = 0;
    int               mode   = 0;
    logic [W-1:0]     exp_q[$];
    logic [N-1:0]     cur_sel;
    logic [6:0]       next_id = 7'd0;

    floo_mcast_fork #(
        .NumOutputs (N),
        .flit_t     (flit_t),
        .EnErrCount (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .sel_i      (sel_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .drop_o     (drop_o),
        .drop_cnt_o (drop_cnt_o),
        .state_o    (state_o),
        .sent_o     (sent_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic last);
        data_i.hdr.last = last;
        data_i.hdr.id   = next_id;
        data_i.payload  = 24'($urandom);
        next_id         = next_id + 7'd1;
    endtask

    // One directed cycle: drive inputs, queue the outputs this cycle must show.
    task automatic step(input logic [N-1:0] sel, input logic [N-1:0] rdy,
                        input logic [N-1:0] ev, input logic er, input logic ed);
        valid_i = 1'b1;
        sel_i   = sel;
        ready_i = rdy;
        exp_q.push_back({ev, er, ed, data_i});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        ready_i = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] e;
        logic [N-1:0] got;
        logic [N-1:0] hs;
        logic [N-1:0] pv;
        logic [N-1:0] phs;
        logic         pr;
        flit_t        pd;
        got = '0;
        pv  = '0;
        phs = '0;
        pr  = 1'b1;
        pd  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got = '0;
                pr  = 1'b1;
                continue;
            end
            if (mode == 0) begin
                if ((|valid_o) || ready_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got valid_o=%b ready_o=%b required nothing",
                                 valid_o, ready_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cycle_out", 64'({valid_o, ready_o, drop_o, data_o}), 64'(e));
                    end
                end
            end else begin
                hs = valid_o & ready_i;
                if (!pr) begin
                    chk("valid_hold", 64'(pv & ~phs & ~valid_o), 64'd0);
                    if (|pv) chk("data_hold", 64'(data_o), 64'(pd));
                end
                chk("no_stray_valid", 64'(valid_o & ~cur_sel), 64'd0);
                chk("no_double_accept", 64'(hs & got), 64'd0);
                got = got | hs;
                if (ready_o) begin
                    chk("fanout_complete", 64'(got), 64'(cur_sel));
                    got = '0;
                end
                pv  = valid_o;
                phs = hs;
                pr  = ready_o;
                pd  = data_o;
            end
        end
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got no end of test, required completion within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        valid_i = 1'b0;
        sel_i   = '0;
        ready_i = '0;
        data_i  = '0;
        cur_sel = '0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd0);
        chk("rst_drop_o", 64'(drop_o), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        chk("rst_state", 64'(state_o), 64'(IDLE));
        chk("rst_sent", 64'(sent_o), 64'd0);
        @(posedge clk);
        #1;

        // Unicast three-flit packet, full rate.
        load(1'b0); step(5'b00100, 5'b11111, 5'b00100, 1'b1, 1'b0);
        chk("uni_in_pkt", 64'(state_o), 64'(BODY));
        load(1'b0); step(5'b00100, 5'b11111, 5'b00100, 1'b1, 1'b0);
        load(1'b1); step(5'b00100, 5'b11111, 5'b00100, 1'b1, 1'b0);
        chk("uni_end_state", 64'(state_o), 64'(IDLE));
        idle();

        // Staggered multicast, single flit.
        load(1'b1); step(5'b10011, 5'b00001, 5'b10011, 1'b0, 1'b0);
        chk("stag_sent0", 64'(sent_o), 64'(5'b00001));
        step(5'b10011, 5'b00000, 5'b10010, 1'b0, 1'b0);
        step(5'b10011, 5'b00010, 5'b10010, 1'b0, 1'b0);
        step(5'b10011, 5'b10000, 5'b10000, 1'b1, 1'b0);
        chk("stag_sent_clr", 64'(sent_o), 64'd0);
        idle();

        // Mask latch: body ignores the changed sel_i; next head samples it.
        load(1'b0); step(5'b01001, 5'b11111, 5'b01001, 1'b1, 1'b0);
        load(1'b0); step(5'b00110, 5'b00110, 5'b01001, 1'b0, 1'b0);
        step(5'b00110, 5'b01001, 5'b01001, 1'b1, 1'b0);
        load(1'b1); step(5'b00110, 5'b11111, 5'b01001, 1'b1, 1'b0);
        chk("latch_end_state", 64'(state_o), 64'(IDLE));
        load(1'b1); step(5'b00110, 5'b11111, 5'b00110, 1'b1, 1'b0);
        idle();

        // Empty mask drops and counter saturation.
        for (int i = 0; i < 4; i++) begin
            load(1'b1); step(5'b00000, 5'b11111, 5'b00000, 1'b1, 1'b1);
        end
        chk("drop_cnt_4", 64'(drop_cnt_o), 64'd4);
        for (int i = 0; i < 65531; i++) step(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1);
        chk("drop_cnt_max", 64'(drop_cnt_o), 64'hFFFF);
        for (int i = 0; i < 5; i++) step(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1);
        chk("drop_cnt_sat", 64'(drop_cnt_o), 64'hFFFF);
        idle();

        // Reset in the middle of a partially accepted body flit.
        load(1'b0); step(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
        load(1'b0); step(5'b00000, 5'b00011, 5'b11111, 1'b0, 1'b0);
        step(5'b00000, 5'b00000, 5'b11100, 1'b0, 1'b0);
        chk("pre_rst_sent", 64'(sent_o), 64'(5'b00011));
        chk("pre_rst_state", 64'(state_o), 64'(BODY));
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_sent", 64'(sent_o), 64'd0);
        chk("mid_rst_state", 64'(state_o), 64'(IDLE));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        load(1'b1); step(5'b11111, 5'b00000, 5'b11111, 1'b0, 1'b0);
        step(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
        chk("post_rst_state", 64'(state_o), 64'(IDLE));
        idle();
        chk("directed_drained", 64'(exp_q.size()), 64'd0);

        // Random back-pressure on random multicast packets.
        mode = 1;
        for (int p = 0; p < 12; p++) begin
            logic [N-1:0] psel;
            int           len;
            psel    = N'($urandom_range(1, 31));
            len     = $urandom_range(1, 3);
            cur_sel = psel;
            for (int f = 0; f < len; f++) begin
                int cyc;
                bit fdone;
                load(f == len - 1);
                valid_i = 1'b1;
                sel_i   = (f == 0) ? psel : N'($urandom_range(0, 31));
                fdone   = 1'b0;
                cyc     = 0;
                while (!fdone && cyc < 64) begin
                    ready_i = N'($urandom_range(0, 31));
                    @(negedge clk);
                    fdone = ready_o;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                if (!fdone) begin
                    checks++;
                    errors++;
                    $display("FAIL flit_timeout: got no completion in %0d cycles, required completion", cyc);
                end
            end
        end
        idle();
        idle();
        chk("final_state", 64'(state_o), 64'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
